frame_fwd_ctrl: RTL and testbench

Store-and-forward scheduler for the MAC-to-FIFO bridge datapath, clocked in the MAC byte domain. Gates writes of received bytes into the byte FIFO and keeps a per-frame length/status queue. Transmits only complete, good frames to the MAC TX side and silently drains bad frames out of the FIFO. Replaces the free-running `write=1` / `read=!empty` hookup and the separate last-byte checker.

---
 rtl/frame_fwd_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_frame_fwd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fwd_ctrl.sv
// ============================================================================
// Module   : frame_fwd_ctrl
// Purpose  : Store-and-forward scheduler between MAC RX, byte FIFO and MAC TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_fwd_ctrl #(
    parameter int DEPTH_LOG2 = 11,
    parameter int LENQ_LOG2  = 2,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic                 rx_last,
    input  logic                 rx_err,
    input  logic                 fifo_full,
    output logic                 fifo_write,
    output logic                 fifo_read,
    output logic                 fifo_clr,
    input  logic                 tx_mac_ready,
    output logic                 tx_mac_valid,
    output logic                 tx_mac_last,
    output logic [LENQ_LOG2:0]   frames_pending,
    output logic [15:0]          drop_count,
    output logic [15:0]          bad_count
);

    localparam int c_LEN_W     = DEPTH_LOG2;
    localparam int c_OCC_W     = DEPTH_LOG2 + 1;
    localparam int c_LENQ_SIZE = 1 << LENQ_LOG2;

    localparam logic [c_OCC_W-1:0]   c_FIFO_SIZE = c_OCC_W'(1 << DEPTH_LOG2);
    localparam logic [c_OCC_W-1:0]   c_MAX_OCC   = c_OCC_W'(MAX_LEN);
    localparam logic [c_OCC_W-1:0]   c_OCC_ONE   = c_OCC_W'(1);
    localparam logic [c_LEN_W-1:0]   c_MAX_LEN   = c_LEN_W'(MAX_LEN);
    localparam logic [c_LEN_W-1:0]   c_MIN_LEN   = c_LEN_W'(MIN_LEN);
    localparam logic [c_LEN_W-1:0]   c_LEN_ONE   = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0]   c_IFG       = c_LEN_W'(IFG_CYCLES);
    localparam logic [LENQ_LOG2-1:0] c_PTR_ONE   = LENQ_LOG2'(1);
    localparam logic [LENQ_LOG2:0]   c_PEND_ONE  = (LENQ_LOG2 + 1)'(1);
    localparam logic [LENQ_LOG2:0]   c_PEND_FULL = (LENQ_LOG2 + 1)'(c_LENQ_SIZE);
    localparam logic [15:0]          c_CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_STORE = 2'd1,
        RX_DROP  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_DRAIN = 2'd2,
        TX_IFG   = 2'd3
    } tx_state_t;

    rx_state_t              rx_state_q, rx_state_d;
    tx_state_t              tx_state_q, tx_state_d;
    logic [c_LEN_W-1:0]     len_q, len_d;
    logic                   bad_q, bad_d;
    logic [c_OCC_W-1:0]     occ_q, occ_d;
    logic [c_LEN_W-1:0]     cnt_q, cnt_d;
    logic [c_LEN_W:0]       lenq_q [c_LENQ_SIZE];
    logic [c_LEN_W:0]       lenq_d [c_LENQ_SIZE];
    logic [LENQ_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LENQ_LOG2:0]     pend_q, pend_d;
    logic                   tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d, bad_cnt_q, bad_cnt_d;

    logic                   w_write, w_read, w_push, w_pop, w_admit, w_wr_ok;
    logic [c_OCC_W-1:0]     w_free;
    logic [c_LEN_W:0]       w_push_desc, w_head;
    logic [c_LEN_W-1:0]     w_len_fin;
    logic                   w_bad_fin;

    assign w_free  = c_FIFO_SIZE - occ_q;
    // Room for a worst-case frame is reserved up front so an admitted frame never overflows.
    assign w_admit = (w_free >= c_MAX_OCC) && (pend_q != c_PEND_FULL);
    assign w_head  = lenq_q[rd_ptr_q];

    always_comb begin
        rx_state_d  = rx_state_q;
        len_d       = len_q;
        bad_d       = bad_q;
        drop_cnt_d  = drop_cnt_q;
        w_write     = 1'b0;
        w_push      = 1'b0;
        w_push_desc = '0;
        w_wr_ok     = 1'b0;
        w_len_fin   = len_q;
        w_bad_fin   = bad_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_valid) begin
                    if (w_admit) begin
                        w_write    = 1'b1;
                        len_d      = c_LEN_ONE;
                        bad_d      = rx_err;
                        rx_state_d = RX_STORE;
                        if (rx_last) begin
                            w_push      = 1'b1;
                            w_push_desc = {rx_err | (c_LEN_ONE < c_MIN_LEN), c_LEN_ONE};
                            rx_state_d  = RX_IDLE;
                        end
                    end else begin
                        if (drop_cnt_q != c_CNT_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
                        rx_state_d = rx_last ? RX_IDLE : RX_DROP;
                    end
                end
            end
            RX_STORE: begin
                if (rx_valid) begin
                    w_wr_ok   = (len_q != c_MAX_LEN) && !fifo_full;
                    w_write   = w_wr_ok;
                    w_len_fin = w_wr_ok ? (len_q + c_LEN_ONE) : len_q;
                    w_bad_fin = bad_q | !w_wr_ok | rx_err;
                    len_d     = w_len_fin;
                    bad_d     = w_bad_fin;
                    if (rx_last) begin
                        w_push      = 1'b1;
                        w_push_desc = {w_bad_fin | (w_len_fin < c_MIN_LEN), w_len_fin};
                        rx_state_d  = RX_IDLE;
                    end
                end
            end
            RX_DROP: begin
                if (rx_valid && rx_last) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        bad_cnt_d  = bad_cnt_q;
        w_pop      = 1'b0;
        w_read     = 1'b0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (pend_q != '0) begin
                    if (w_head[c_LEN_W]) begin
                        w_pop      = 1'b1;
                        cnt_d      = w_head[c_LEN_W-1:0];
                        tx_state_d = TX_DRAIN;
                        if (bad_cnt_q != c_CNT_MAX) bad_cnt_d = bad_cnt_q + 16'd1;
                    end else if (tx_mac_ready) begin
                        w_pop      = 1'b1;
                        cnt_d      = w_head[c_LEN_W-1:0];
                        tx_state_d = TX_SEND;
                    end
                end
            end
            TX_SEND: begin
                // FIFO data lags the read by one cycle, so valid/last are registered copies.
                w_read     = 1'b1;
                tx_valid_d = 1'b1;
                tx_last_d  = (cnt_q == c_LEN_ONE);
                cnt_d      = cnt_q - c_LEN_ONE;
                if (cnt_q == c_LEN_ONE) begin
                    cnt_d      = c_IFG;
                    tx_state_d = (IFG_CYCLES == 0) ? TX_IDLE : TX_IFG;
                end
            end
            TX_DRAIN: begin
                w_read = 1'b1;
                cnt_d  = cnt_q - c_LEN_ONE;
                if (cnt_q == c_LEN_ONE) tx_state_d = TX_IDLE;
            end
            TX_IFG: begin
                cnt_d = cnt_q - c_LEN_ONE;
                if (cnt_q == c_LEN_ONE) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({w_write, w_read})
            2'b10:   occ_d = occ_q + c_OCC_ONE;
            2'b01:   occ_d = occ_q - c_OCC_ONE;
            default: occ_d = occ_q;
        endcase
        lenq_d   = lenq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            lenq_d[wr_ptr_q] = w_push_desc;
            wr_ptr_d         = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        pend_d = pend_q;
        case ({w_push, w_pop})
            2'b10:   pend_d = pend_q + c_PEND_ONE;
            2'b01:   pend_d = pend_q - c_PEND_ONE;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            len_q      <= '0;
            bad_q      <= 1'b0;
            occ_q      <= '0;
            cnt_q      <= '0;
            lenq_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pend_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            drop_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            len_q      <= len_d;
            bad_q      <= bad_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            lenq_q     <= lenq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pend_q     <= pend_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            drop_cnt_q <= drop_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign fifo_clr       = rst;
    assign fifo_write     = w_write & ~rst;
    assign fifo_read      = w_read & ~rst;
    assign tx_mac_valid   = tx_valid_q;
    assign tx_mac_last    = tx_last_q;
    assign frames_pending = pend_q;
    assign drop_count     = drop_cnt_q;
    assign bad_count      = bad_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_fwd_ctrl.sv
// ============================================================================
// Module   : tb_frame_fwd_ctrl
// Purpose  : Scoreboard bench for frame_fwd_ctrl with directed frame vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_fwd_ctrl;

    localparam int c_IFG = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0, rx_last = 1'b0, rx_err = 1'b0;
    logic        fifo_full = 1'b0, tx_mac_ready = 1'b1;
    logic        fifo_write, fifo_read, fifo_clr, tx_mac_valid, tx_mac_last;
    logic [2:0]  frames_pending;
    logic [15:0] drop_count, bad_count;

    frame_fwd_ctrl dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_last(rx_last), .rx_err(rx_err),
        .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_read(fifo_read),
        .fifo_clr(fifo_clr), .tx_mac_ready(tx_mac_ready), .tx_mac_valid(tx_mac_valid),
        .tx_mac_last(tx_mac_last), .frames_pending(frames_pending),
        .drop_count(drop_count), .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit good;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, last_rx_cyc = 0;
    int   wr_cnt = 0, rd_cnt = 0, stray = 0;
    bit   in_burst = 0, have_prev = 0, prev_good = 0;
    int   b_start = 0, b_len = 0, v_cnt = 0, l_cnt = 0, l_cyc = 0;
    int   prev_start = 0, prev_len = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: frames one fifo_read burst at a time and scores it against the queue head.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_burst  = 0;
            have_prev = 0;
        end else begin
            if (fifo_write) wr_cnt++;
            if (fifo_read && !in_burst) begin
                in_burst = 1;
                b_start  = cyc;
                b_len    = 0;
                v_cnt    = 0;
                l_cnt    = 0;
                l_cyc    = -1;
                starts.push_back(cyc);
                if (have_prev && prev_good)
                    check("ifg_min", int'(cyc >= prev_start + prev_len + c_IFG + 1), 1);
            end
            if (in_burst) begin
                if (tx_mac_valid) v_cnt++;
                if (tx_mac_last) begin
                    l_cnt++;
                    l_cyc = cyc;
                end
            end else if (tx_mac_valid || tx_mac_last) begin
                stray++;
            end
            if (fifo_read) begin
                b_len++;
                rd_cnt++;
            end
            if (in_burst && !fifo_read) begin
                in_burst = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got burst of %0d reads, expected none", b_len);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("read_len", b_len, e.len);
                    check("valid_cnt", v_cnt, e.good ? e.len : 0);
                    check("last_cnt", l_cnt, e.good ? 1 : 0);
                    if (e.good) check("last_pos", l_cyc, b_start + e.len);
                    have_prev  = 1;
                    prev_good  = e.good;
                    prev_start = b_start;
                    prev_len   = b_len;
                end
            end
        end
    end

    task automatic expect_frame(input bit good, input int len);
        exp_t e;
        e.good = good;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        exp_q.delete();
        starts.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_fifo_clr", int'(fifo_clr), 1);
        check("rst_fifo_write", int'(fifo_write), 0);
        check("rst_fifo_read", int'(fifo_read), 0);
        check("rst_tx_valid", int'(tx_mac_valid), 0);
        check("rst_tx_last", int'(tx_mac_last), 0);
        check("rst_pending", int'(frames_pending), 0);
        check("rst_drop_count", int'(drop_count), 0);
        check("rst_bad_count", int'(bad_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps, input int err_at);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_last  = (i == n - 1);
            rx_err   = (i == err_at);
            if (i == n - 1) last_rx_cyc = cyc;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            rx_err   = 1'b0;
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_burst) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_in_budget", int'(n < budget), 1);
    endtask

    initial begin
        #1;
        // Good 64-byte frame with a gap after every byte.
        do_reset();
        tx_mac_ready = 1'b1;
        expect_frame(1, 64);
        send_frame(64, 1, -1);
        wait_drain(400);
        check("good_writes", wr_cnt, 64);
        check("good_reads", rd_cnt, 64);
        check("start_latency", (starts.size() > 0) ? starts[0] : -1, last_rx_cyc + 2);
        check("good_bad_count", int'(bad_count), 0);
        check("fifo_clr_idle", int'(fifo_clr), 0);

        // PHY error on byte 50 of 100.
        do_reset();
        expect_frame(0, 100);
        send_frame(100, 0, 49);
        wait_drain(400);
        check("err_bad_count", int'(bad_count), 1);
        check("err_reads", rd_cnt, 100);

        // Runts: 40 bytes then a single byte, drained back to back.
        do_reset();
        expect_frame(0, 40);
        expect_frame(0, 1);
        send_frame(40, 0, -1);
        send_frame(1, 0, -1);
        wait_drain(400);
        check("runt_bad_count", int'(bad_count), 2);
        check("drain_b2b", (starts.size() == 2) ? starts[1] - starts[0] : -1, 41);

        // Oversize frame truncated at 1518 stored bytes.
        do_reset();
        expect_frame(0, 1518);
        send_frame(1600, 0, -1);
        wait_drain(2000);
        check("long_writes", wr_cnt, 1518);
        check("long_occ_zero", wr_cnt - rd_cnt, 0);
        check("long_bad_count", int'(bad_count), 1);

        // Queue fills with the MAC stalled; the fifth frame is dropped.
        do_reset();
        tx_mac_ready = 1'b0;
        for (int k = 0; k < 4; k++) expect_frame(1, 64);
        for (int k = 0; k < 5; k++) send_frame(64, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        check("full_pending", int'(frames_pending), 4);
        check("full_drop_count", int'(drop_count), 1);
        check("full_writes", wr_cnt, 256);
        check("full_no_reads", rd_cnt, 0);
        tx_mac_ready = 1'b1;
        wait_drain(1000);
        check("full_frames_out", starts.size(), 4);
        for (int k = 1; k < 4; k++)
            check("full_gap", (starts.size() > k) ? starts[k] - starts[k-1] : -1, 64 + c_IFG + 1);
        check("full_pending_empty", int'(frames_pending), 0);

        // Reset while a frame is being sent, then a clean frame.
        do_reset();
        expect_frame(1, 64);
        send_frame(64, 0, -1);
        begin
            int n = 0;
            while (rd_cnt < 10 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("midsend_reached", int'(rd_cnt >= 10), 1);
        end
        do_reset();
        check("post_rst_fifo_clr", int'(fifo_clr), 0);
        check("post_rst_fifo_read", int'(fifo_read), 0);
        expect_frame(1, 64);
        send_frame(64, 1, -1);
        wait_drain(400);
        check("post_rst_writes", wr_cnt, 64);
        check("post_rst_reads", rd_cnt, 64);

        check("stray_tx_valid", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
